// File: rtl/glitch_window_ctrl_if.sv
// Control/status bundle between the glitch sequencer and its host/trigger logic.
// master drives config, arm/disarm and triggers; slave is the sequencer itself.
interface glitch_window_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int REP_W  = 8
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic              arm_i;
  logic              disarm_i;
  logic [NUM_CH-1:0] ch_en_i;
  logic [NUM_CH-1:0] trig_i;
  logic [CNT_W-1:0]  delay_i;
  logic [CNT_W-1:0]  width_i;
  logic [CNT_W-1:0]  gap_i;
  logic [REP_W-1:0]  repeat_i;
  logic              glitch_sel_o;
  logic              armed_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [CH_W-1:0]   trig_ch_o;

  modport master (
    output arm_i, disarm_i, ch_en_i, trig_i, delay_i, width_i, gap_i, repeat_i,
    input  glitch_sel_o, armed_o, busy_o, done_o, err_o, trig_ch_o
  );

  modport slave (
    input  arm_i, disarm_i, ch_en_i, trig_i, delay_i, width_i, gap_i, repeat_i,
    output glitch_sel_o, armed_o, busy_o, done_o, err_o, trig_ch_o
  );
endinterface

// File: rtl/glitch_window_ctrl.sv
// Sequenced clock-glitch window generator: after a synchronised trigger edge, waits
// delay cycles then emits (repeat+1) select pulses of fixed width separated by a gap.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | config latched, watching enabled trigger edges
// DELAY   | counting down from trigger to first pulse
// PULSE   | glitch_sel_o high for width cycles
// GAP     | glitch_sel_o low for max(gap,1) cycles
// DONE    | one-cycle done_o, then IDLE
module glitch_window_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int REP_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  glitch_window_ctrl_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_GAP, S_DONE} state_t;

  state_t                               state;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]   sync_q;
  logic [NUM_CH-1:0]                    trig_prev;
  logic [NUM_CH-1:0]                    rise_q;
  logic [NUM_CH-1:0]                    ch_en_q;
  logic [CNT_W-1:0]                     delay_q, width_q, gap_q, cnt;
  logic [REP_W-1:0]                     rep_cnt;
  logic [CH_W-1:0]                      win_idx;

  // Edges are only recorded while ARMED so a trigger that rose before arm cannot fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      trig_prev <= '0;
      rise_q    <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.trig_i};
      trig_prev <= sync_q[SYNC_STAGES-1];
      rise_q    <= sync_q[SYNC_STAGES-1] & ~trig_prev & ch_en_q
                   & {NUM_CH{state == S_ARMED}};
    end
  end

  always_comb begin
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rise_q[i]) win_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      ch_en_q          <= '0;
      delay_q          <= '0;
      width_q          <= '0;
      gap_q            <= '0;
      cnt              <= '0;
      rep_cnt          <= '0;
      bus.glitch_sel_o <= 1'b0;
      bus.armed_o      <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.trig_ch_o    <= '0;
    end else begin
      bus.done_o <= 1'b0;
      bus.err_o  <= 1'b0;
      if (bus.disarm_i) begin
        state            <= S_IDLE;
        bus.glitch_sel_o <= 1'b0;
        bus.armed_o      <= 1'b0;
        bus.busy_o       <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.arm_i) begin
              if (bus.width_i == '0 || bus.ch_en_i == '0) begin
                bus.err_o <= 1'b1;
              end else begin
                state         <= S_ARMED;
                bus.armed_o   <= 1'b1;
                bus.trig_ch_o <= '0;
                ch_en_q       <= bus.ch_en_i;
                delay_q       <= bus.delay_i;
                width_q       <= bus.width_i;
                gap_q         <= bus.gap_i;
                rep_cnt       <= bus.repeat_i;
              end
            end
          end
          S_ARMED: begin
            if (rise_q != '0) begin
              bus.trig_ch_o <= win_idx;
              bus.armed_o   <= 1'b0;
              bus.busy_o    <= 1'b1;
              if (delay_q == '0) begin
                state            <= S_PULSE;
                bus.glitch_sel_o <= 1'b1;
                cnt              <= width_q - CNT_W'(1);
              end else begin
                state <= S_DELAY;
                cnt   <= delay_q - CNT_W'(1);
              end
            end
          end
          S_DELAY: begin
            if (cnt == '0) begin
              state            <= S_PULSE;
              bus.glitch_sel_o <= 1'b1;
              cnt              <= width_q - CNT_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_PULSE: begin
            if (cnt == '0) begin
              bus.glitch_sel_o <= 1'b0;
              if (rep_cnt == '0) begin
                state      <= S_DONE;
                bus.busy_o <= 1'b0;
                bus.done_o <= 1'b1;
              end else begin
                state <= S_GAP;
                cnt   <= (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_GAP: begin
            if (cnt == '0) begin
              state            <= S_PULSE;
              bus.glitch_sel_o <= 1'b1;
              cnt              <= width_q - CNT_W'(1);
              rep_cnt          <= rep_cnt - REP_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_glitch_window_ctrl.sv
// Randomised bench for glitch_window_ctrl; expected select/status traces are derived
// from pulse-window arithmetic (start, period, end) rather than a state machine.
module tb_glitch_window_ctrl;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int REP_W  = 8;
  localparam int SYNC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  glitch_window_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  glitch_window_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // {sel, busy, armed, done, err}
  function automatic logic [4:0] obs();
    return {bus.glitch_sel_o, bus.busy_o, bus.armed_o, bus.done_o, bus.err_o};
  endfunction

  task automatic set_cfg(input int dly, input int wid, input int gp, input int rep, input int mask);
    bus.delay_i  = CNT_W'(dly);
    bus.width_i  = CNT_W'(wid);
    bus.gap_i    = CNT_W'(gp);
    bus.repeat_i = REP_W'(rep);
    bus.ch_en_i  = NUM_CH'(mask);
  endtask

  // abort_kind: 0 none, 1 disarm, 2 rst; abort_off < 0 picks a random offset.
  task automatic run_seq(input int dly, input int wid, input int gp, input int rep,
                         input int mask, input int bits, input int abort_kind, input int abort_off);
    int T, start, g, P, endc, last, abort_edge, win, pre, c, off;
    bit fire;
    logic [4:0] exp;
    set_cfg(dly, wid, gp, rep, mask);
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    check("arm_ok", 32'(obs()), 32'b00100);
    pre = $urandom_range(0, 2);
    repeat (pre) begin
      tick();
      check("armed_wait", 32'(obs()), 32'b00100);
    end
    bus.trig_i = NUM_CH'(bits);
    T = cyc + 1;
    fire = 1'b0;
    win = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (((bits & mask) >> i) & 1) begin
        fire = 1'b1;
        win = i;
      end
    end
    g     = (gp == 0) ? 1 : gp;
    P     = wid + g;
    start = T + SYNC + 1 + dly;
    endc  = start + rep * P + wid;
    last  = fire ? endc + 2 : T + 12;
    off   = (abort_off < 0) ? $urandom_range(1, last - T) : abort_off;
    abort_edge = (abort_kind != 0) ? T + off : 32'h3fff_ffff;
    while (cyc < last) begin
      bus.disarm_i = (abort_kind == 1 && cyc + 1 == abort_edge);
      rst          = (abort_kind == 2 && cyc + 1 == abort_edge);
      if (fire && cyc + 1 == T + 4 && T + 4 < abort_edge && T + 4 < endc) begin
        set_cfg(0, 0, 0, 0, 0);
        bus.arm_i = 1'b1;
      end
      tick();
      bus.arm_i = 1'b0;
      c = cyc;
      if (c >= abort_edge) exp = '0;
      else begin
        exp[4] = fire && c >= start && c < endc && ((c - start) % P) < wid;
        exp[3] = fire && c >= start - dly && c < endc;
        exp[2] = !(fire && c >= start - dly);
        exp[1] = fire && c == endc;
        exp[0] = 1'b0;
      end
      check("seq", 32'(obs()), 32'(exp));
    end
    bus.disarm_i = 1'b0;
    rst = 1'b0;
    if (abort_kind == 2 && abort_edge <= last) check("trig_ch_rst", 32'(bus.trig_ch_o), 0);
    else if (fire && start - dly < abort_edge) check("trig_ch", 32'(bus.trig_ch_o), 32'(win));
    else check("trig_ch_none", 32'(bus.trig_ch_o), 0);
    bus.disarm_i = 1'b1;
    tick();
    bus.disarm_i = 1'b0;
    check("cleanup", 32'(obs()), 0);
    bus.trig_i = '0;
    repeat (SYNC + 2) tick();
  endtask

  initial begin
    int dly, wid, gp, rep, mask, bits, kind;
    bus.arm_i = 1'b0;
    bus.disarm_i = 1'b0;
    bus.trig_i = '0;
    set_cfg(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_out", 32'(obs()), 0);
    check("reset_ch", 32'(bus.trig_ch_o), 0);
    rst = 1'b0;
    tick();

    run_seq(3, 2, 0, 0, 1, 1, 0, 0);
    run_seq(1, 4, 0, 2, 3, 1, 0, 0);
    run_seq(2, 1, 1, 0, 3, 3, 0, 0);
    run_seq(2, 1, 1, 0, 2, 3, 0, 0);
    run_seq(1, 4, 2, 2, 1, 1, 1, 11);

    set_cfg(1, 0, 1, 0, 1);
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    check("err_width0", 32'(obs()), 32'b00001);
    tick();
    check("err_clear", 32'(obs()), 0);
    set_cfg(1, 2, 1, 0, 0);
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    check("err_mask0", 32'(obs()), 32'b00001);
    set_cfg(1, 2, 1, 0, 1);
    bus.arm_i = 1'b1;
    bus.disarm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    bus.disarm_i = 1'b0;
    check("arm_disarm", 32'(obs()), 0);

    bus.trig_i = 2'b01;
    repeat (4) tick();
    set_cfg(0, 1, 1, 0, 1);
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    repeat (8) begin
      tick();
      check("level_hold", 32'(obs()), 32'b00100);
    end
    bus.disarm_i = 1'b1;
    tick();
    bus.disarm_i = 1'b0;
    bus.trig_i = '0;
    repeat (4) tick();

    set_cfg(16'hffff, 1, 1, 0, 1);
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    bus.trig_i = 2'b01;
    repeat (10) tick();
    check("long_delay_busy", 32'(obs()), 32'b01000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid", 32'(obs()), 0);
    check("rst_mid_ch", 32'(bus.trig_ch_o), 0);
    bus.trig_i = '0;
    repeat (4) tick();

    for (int n = 0; n < 40; n++) begin
      dly  = $urandom_range(0, 12);
      wid  = $urandom_range(1, 6);
      gp   = $urandom_range(0, 4);
      rep  = $urandom_range(0, 3);
      mask = $urandom_range(1, 3);
      bits = $urandom_range(1, 3);
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_seq(dly, wid, gp, rep, mask, bits, kind, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
